// File: rtl/seq_pattern_pkg.sv
// Shared types and helpers for the sequence pattern checker and its pattern table.
package seq_pattern_pkg;

  localparam int DEF_W      = 10;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNTW   = 8;
  localparam int DEF_THRESH = 5;

  // Widest vector masked_eq accepts; callers zero-extend narrower operands.
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  function automatic logic masked_eq(input logic [MAX_W-1:0] x,
                                     input logic [MAX_W-1:0] mask,
                                     input logic [MAX_W-1:0] val);
    return ((x ^ val) & mask) == '0;
  endfunction

endpackage

// File: rtl/seq_pattern_checker_if.sv
// Bundles the monitored vector, configuration writes and result outputs of the checker.
interface seq_pattern_checker_if #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
);
  localparam int IW = $clog2(DEPTH);

  logic            en;
  logic [W-1:0]    x;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [W-1:0]    cfg_mask;
  logic [W-1:0]    cfg_val;
  logic            len_we;
  logic [IW:0]     cfg_len;
  logic            alarm_clr;
  logic [IW-1:0]   step;
  logic            match;
  logic            mismatch;
  logic [CNTW-1:0] hit_count;
  logic            alarm;

  modport master (
    output en, x, cfg_we, cfg_idx, cfg_mask, cfg_val, len_we, cfg_len, alarm_clr,
    input  step, match, mismatch, hit_count, alarm
  );

  modport slave (
    input  en, x, cfg_we, cfg_idx, cfg_mask, cfg_val, len_we, cfg_len, alarm_clr,
    output step, match, mismatch, hit_count, alarm
  );

endinterface

// File: rtl/seq_pattern_table.sv
// DEPTH-entry (mask, val) register file with one write port and two read ports:
// the entry currently expected and entry 0 (used for restart after a break).
module seq_pattern_table #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [W-1:0]  wmask,
  input  logic [W-1:0]  wval,
  input  logic [IW-1:0] ridx,
  output logic [W-1:0]  rmask,
  output logic [W-1:0]  rval,
  output logic [W-1:0]  mask0,
  output logic [W-1:0]  val0
);

  logic [W-1:0] mask_q [DEPTH];
  logic [W-1:0] val_q  [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= '0;
        val_q[i]  <= '0;
      end
    end else if (we) begin
      mask_q[widx] <= wmask;
      val_q[widx]  <= wval;
    end
  end

  assign rmask = mask_q[ridx];
  assign rval  = val_q[ridx];
  assign mask0 = mask_q[0];
  assign val0  = val_q[0];

endmodule

// File: rtl/seq_pattern_checker.sv
// Programmable masked-sequence checker: tracks progress through up to DEPTH
// patterns, pulses match/mismatch, counts hits (saturating) and raises a sticky alarm.
module seq_pattern_checker
  import seq_pattern_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNTW   = DEF_CNTW,
  parameter int THRESH = DEF_THRESH
) (
  input logic                clk,
  input logic                rst,
  seq_pattern_checker_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] THR     = CNTW'(THRESH);

  state_t          state, state_nxt;
  logic [IW-1:0]   step_q, step_nxt;
  logic [LW-1:0]   len_q;
  logic            match_q, mismatch_q, alarm_q;
  logic [CNTW-1:0] hit_count_q, cnt_inc;
  logic            hit_now, break_now;
  logic [W-1:0]    cur_mask, cur_val, first_mask, first_val;
  logic            hit_cur, hit_first, is_last;

  seq_pattern_table #(.W(W), .DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.cfg_we),
    .widx  (bus.cfg_idx),
    .wmask (bus.cfg_mask),
    .wval  (bus.cfg_val),
    .ridx  (step_q),
    .rmask (cur_mask),
    .rval  (cur_val),
    .mask0 (first_mask),
    .val0  (first_val)
  );

  assign hit_cur   = masked_eq(MAX_W'(bus.x), MAX_W'(cur_mask), MAX_W'(cur_val));
  assign hit_first = masked_eq(MAX_W'(bus.x), MAX_W'(first_mask), MAX_W'(first_val));
  assign is_last   = ({1'b0, step_q} == (len_q - LW'(1)));
  assign cnt_inc   = (hit_count_q == CNT_MAX) ? hit_count_q : hit_count_q + 1'b1;

  // A config write during a sequence abandons it silently; otherwise advance,
  // complete, or break (restarting at step 1 if the sample also matches entry 0).
  always_comb begin
    state_nxt = state;
    step_nxt  = step_q;
    hit_now   = 1'b0;
    break_now = 1'b0;
    if ((bus.cfg_we || bus.len_we) && state == TRACK) begin
      state_nxt = IDLE;
      step_nxt  = '0;
    end else if (bus.en && len_q != '0) begin
      if (state == IDLE) begin
        if (hit_first) begin
          if (len_q == LW'(1)) begin
            hit_now = 1'b1;
          end else begin
            state_nxt = TRACK;
            step_nxt  = IW'(1);
          end
        end
      end else if (hit_cur) begin
        if (is_last) begin
          hit_now   = 1'b1;
          state_nxt = IDLE;
          step_nxt  = '0;
        end else begin
          step_nxt = step_q + 1'b1;
        end
      end else begin
        break_now = 1'b1;
        if (hit_first) begin
          step_nxt = IW'(1);
        end else begin
          state_nxt = IDLE;
          step_nxt  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      step_q      <= '0;
      len_q       <= '0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      hit_count_q <= '0;
      alarm_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_q     <= step_nxt;
      match_q    <= hit_now;
      mismatch_q <= break_now;
      if (bus.len_we) begin
        len_q <= (bus.cfg_len > DEPTH_L) ? DEPTH_L : bus.cfg_len;
      end
      // Clear beats a coincident hit; the match pulse itself is unaffected.
      if (bus.alarm_clr) begin
        hit_count_q <= '0;
        alarm_q     <= 1'b0;
      end else if (hit_now) begin
        hit_count_q <= cnt_inc;
        if (cnt_inc >= THR) begin
          alarm_q <= 1'b1;
        end
      end
    end
  end

  assign bus.step      = step_q;
  assign bus.match     = match_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.hit_count = hit_count_q;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_seq_pattern_checker.sv
// Directed and randomized checks of seq_pattern_checker against a sequence-progress model.
module tb_seq_pattern_checker;
  import seq_pattern_pkg::*;

  localparam int W      = 10;
  localparam int DEPTH  = 8;
  localparam int IW     = $clog2(DEPTH);
  localparam int CNTW   = 8;
  localparam int THRESH = 5;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_pattern_checker_if #(.W(W), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();
  seq_pattern_checker_if #(.W(W), .DEPTH(DEPTH), .CNTW(3))    bus_s ();

  seq_pattern_checker #(.W(W), .DEPTH(DEPTH), .CNTW(CNTW), .THRESH(THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seq_pattern_checker #(.W(W), .DEPTH(DEPTH), .CNTW(3), .THRESH(7)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: how many entries of the sequence have been seen so far.
  int           m_step, m_len, m_cnt;
  bit           m_match, m_mis, m_alarm;
  logic [W-1:0] m_mask [DEPTH];
  logic [W-1:0] m_val  [DEPTH];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit entryHit(input int k, input logic [W-1:0] xv);
    return ((xv ^ m_val[k]) & m_mask[k]) == '0;
  endfunction

  task automatic modelReset();
    m_step = 0; m_len = 0; m_cnt = 0;
    m_match = 0; m_mis = 0; m_alarm = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mask[i] = '0;
      m_val[i]  = '0;
    end
  endtask

  task automatic modelStep();
    logic [W-1:0] xv;
    xv = bus.x;
    m_match = 0;
    m_mis   = 0;
    if ((bus.cfg_we || bus.len_we) && m_step != 0) begin
      m_step = 0;
    end else if (bus.en && m_len != 0) begin
      if (entryHit(m_step, xv)) begin
        if (m_step == m_len - 1) begin
          m_match = 1;
          m_step  = 0;
        end else begin
          m_step++;
        end
      end else if (m_step != 0) begin
        m_mis  = 1;
        m_step = entryHit(0, xv) ? 1 : 0;
      end
    end
    if (bus.alarm_clr) begin
      m_cnt   = 0;
      m_alarm = 0;
    end else if (m_match) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_cnt >= THRESH) m_alarm = 1;
    end
    if (bus.cfg_we) begin
      m_mask[bus.cfg_idx] = bus.cfg_mask;
      m_val[bus.cfg_idx]  = bus.cfg_val;
    end
    if (bus.len_we) m_len = (int'(bus.cfg_len) > DEPTH) ? DEPTH : int'(bus.cfg_len);
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("step",      32'(bus.step),      32'(m_step));
    checkOutput("match",     32'(bus.match),     32'(m_match));
    checkOutput("mismatch",  32'(bus.mismatch),  32'(m_mis));
    checkOutput("hit_count", 32'(bus.hit_count), 32'(m_cnt));
    checkOutput("alarm",     32'(bus.alarm),     32'(m_alarm));
  endtask

  task automatic idleIn();
    bus.en = 0; bus.x = '0; bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_mask = '0;
    bus.cfg_val = '0; bus.len_we = 0; bus.cfg_len = '0; bus.alarm_clr = 0;
  endtask

  task automatic writeEntry(input int idx, input logic [W-1:0] mk, input logic [W-1:0] v);
    bus.en = 0; bus.cfg_we = 1; bus.cfg_idx = IW'(idx); bus.cfg_mask = mk; bus.cfg_val = v;
    applyStimulus();
    bus.cfg_we = 0;
  endtask

  task automatic setLen(input int n);
    bus.en = 0; bus.len_we = 1; bus.cfg_len = (IW+1)'(n);
    applyStimulus();
    bus.len_we = 0;
  endtask

  task automatic drive(input logic [W-1:0] xv);
    bus.en = 1; bus.x = xv;
    applyStimulus();
  endtask

  task automatic drive124();
    drive(10'h001); drive(10'h002); drive(10'h004);
  endtask

  task automatic loadBasic();
    writeEntry(0, 10'h3FF, 10'h001);
    writeEntry(1, 10'h3FF, 10'h002);
    writeEntry(2, 10'h3FF, 10'h004);
    setLen(3);
  endtask

  task automatic runRandom();
    int r, k;
    for (int ph = 0; ph < 15; ph++) begin
      for (int e = 0; e < DEPTH; e++) writeEntry(e, W'($urandom & $urandom), W'($urandom));
      setLen(int'($urandom_range(0, DEPTH + 3)));
      for (int c = 0; c < 150; c++) begin
        r = int'($urandom_range(0, 99));
        k = (r < 70) ? m_step : 0;
        bus.en = ($urandom_range(0, 9) != 0);
        if (r < 80) bus.x = (m_val[k] & m_mask[k]) | (W'($urandom) & ~m_mask[k]);
        else        bus.x = W'($urandom);
        bus.cfg_we   = ($urandom_range(0, 99) == 0);
        bus.cfg_idx  = IW'($urandom);
        bus.cfg_mask = W'($urandom & $urandom);
        bus.cfg_val  = W'($urandom);
        bus.len_we   = ($urandom_range(0, 99) == 0);
        bus.cfg_len  = (IW+1)'($urandom);
        bus.alarm_clr = ($urandom_range(0, 49) == 0);
        applyStimulus();
      end
      idleIn();
    end
  endtask

  initial begin
    idleIn();
    bus_s.en = 0; bus_s.x = '0; bus_s.cfg_we = 0; bus_s.cfg_idx = '0; bus_s.cfg_mask = '0;
    bus_s.cfg_val = '0; bus_s.len_we = 0; bus_s.cfg_len = '0; bus_s.alarm_clr = 0;
    modelReset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_step",  32'(bus.step),      32'd0);
    checkOutput("rst_hits",  32'(bus.hit_count), 32'd0);
    checkOutput("rst_alarm", 32'(bus.alarm),     32'd0);
    @(negedge clk);
    rst = 1;

    // Disabled block ignores everything
    repeat (5) drive(10'h3FF);
    checkOutput("t1_match", 32'(bus.match),     32'd0);
    checkOutput("t1_step",  32'(bus.step),      32'd0);
    checkOutput("t1_hits",  32'(bus.hit_count), 32'd0);

    loadBasic();
    drive124();
    checkOutput("t2_match", 32'(bus.match),     32'd1);
    checkOutput("t2_hits",  32'(bus.hit_count), 32'd1);
    checkOutput("t2_step",  32'(bus.step),      32'd0);

    bus.alarm_clr = 1; drive(10'h000); bus.alarm_clr = 0;
    drive(10'h001); drive(10'h002); drive(10'h001);
    checkOutput("t3_mismatch", 32'(bus.mismatch), 32'd1);
    checkOutput("t3_restart",  32'(bus.step),     32'd1);
    drive(10'h002); drive(10'h004);
    checkOutput("t3_match", 32'(bus.match),     32'd1);
    checkOutput("t3_hits",  32'(bus.hit_count), 32'd1);

    bus.alarm_clr = 1; drive(10'h000); bus.alarm_clr = 0;
    for (int i = 1; i <= 5; i++) begin
      drive124();
      checkOutput("t4_alarm", 32'(bus.alarm), (i == 5) ? 32'd1 : 32'd0);
    end
    checkOutput("t4_hits5", 32'(bus.hit_count), 32'd5);
    drive124();
    checkOutput("t4_hits6",  32'(bus.hit_count), 32'd6);
    checkOutput("t4_alarm6", 32'(bus.alarm),     32'd1);
    bus.en = 0; bus.alarm_clr = 1; applyStimulus(); bus.alarm_clr = 0;
    checkOutput("t4_clr_hits",  32'(bus.hit_count), 32'd0);
    checkOutput("t4_clr_alarm", 32'(bus.alarm),     32'd0);

    drive(10'h001); drive(10'h002);
    checkOutput("t5_step2", 32'(bus.step), 32'd2);
    writeEntry(0, 10'h3FF, 10'h001);
    checkOutput("t5_abort_step", 32'(bus.step),     32'd0);
    checkOutput("t5_abort_mis",  32'(bus.mismatch), 32'd0);
    drive124();
    drive(10'h001);
    checkOutput("t5_pre_rst", 32'(bus.hit_count), 32'd1);
    rst = 0;
    #1;
    modelReset();
    checkOutput("t5_rst_step",  32'(bus.step),      32'd0);
    checkOutput("t5_rst_hits",  32'(bus.hit_count), 32'd0);
    checkOutput("t5_rst_alarm", 32'(bus.alarm),     32'd0);
    idleIn();
    @(negedge clk);
    rst = 1;
    drive(10'h001); drive(10'h002); drive(10'h004);
    checkOutput("t5_disabled", 32'(bus.match), 32'd0);

    loadBasic();
    drive(10'h001);
    repeat (4) begin bus.en = 0; bus.x = W'($urandom); applyStimulus(); end
    drive(10'h002);
    repeat (4) begin bus.en = 0; bus.x = W'($urandom); applyStimulus(); end
    drive(10'h004);
    checkOutput("t6_match", 32'(bus.match), 32'd1);
    idleIn();

    // Small-counter instance: single always-matching entry, 9 hits
    bus_s.cfg_we = 1; bus_s.cfg_idx = '0; bus_s.cfg_mask = '0; bus_s.cfg_val = '0;
    bus_s.len_we = 1; bus_s.cfg_len = 4'd1;
    @(posedge clk); #1;
    bus_s.cfg_we = 0; bus_s.len_we = 0; bus_s.en = 1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      checkOutput("sat_hits",  32'(bus_s.hit_count), 32'((i < 7) ? i : 7));
      checkOutput("sat_alarm", 32'(bus_s.alarm),     32'(i >= 7));
    end
    bus_s.en = 0;

    runRandom();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
